// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: SPI mode encodings, FSM states
// and the default word width.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  // Modes are written as {CKP, CPH}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall detection
// against a one-cycle-delayed copy of the synchronized value.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic preset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{preset}};
      prev  <= preset;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI slave: oversamples SCK/CS/MOSI on CLK, receives MSB-first words in any
// CKP/CPH mode and shifts a preloaded response word out on MISO.
module spi_slave_receiver
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              SCK,
  input  logic              CS,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_W-1:0]      rx_shift, tx_shift;
  logic                   ckp_l, cph_l;
  logic                   miso;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_q;

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic sck_edge, lead, trail, sample, shift;

  logic latch_mode, load, take_bit, shift_out, present, commit;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (CLK),
    .rst_n  (RESET),
    .preset (CKP),
    .din    (SCK),
    .q      (sck_q),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (CLK),
    .rst_n  (RESET),
    .preset (1'b1),
    .din    (CS),
    .q      (cs_q),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  // A leading edge moves SCK away from its latched idle level
  assign sck_edge = sck_rise | sck_fall;
  assign lead     = sck_edge & (sck_q ^ ckp_l);
  assign trail    = sck_edge & ~(sck_q ^ ckp_l);
  assign sample   = cph_l ? trail : lead;
  assign shift    = cph_l ? lead  : trail;

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_mode = 1'b0;
    load       = 1'b0;
    take_bit   = 1'b0;
    shift_out  = 1'b0;
    present    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          latch_mode = 1'b1;
          load       = 1'b1;
          state_nxt  = ACTIVE;
        end
      end
      ACTIVE: begin
        take_bit = sample;
        // Before the first sample only CPH=1 has a bit to present
        shift_out = shift && (cnt != CNT_FULL);
        present   = shift && (cnt == CNT_FULL) && cph_l;
        if (sample && cnt == CNT_ONE) state_nxt = DONE;
        else if (cs_rise)             state_nxt = IDLE;
      end
      DONE: begin
        commit = 1'b1;
        if (!cs_q) begin
          load      = 1'b1;
          state_nxt = ACTIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt      <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      ckp_l    <= 1'b0;
      cph_l    <= 1'b0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= commit;
      if (latch_mode) begin
        ckp_l <= CKP;
        cph_l <= CPH;
      end
      if (load) begin
        tx_shift <= tx_data;
        cnt      <= CNT_FULL;
        miso     <= (latch_mode ? CPH : cph_l) ? 1'b0 : tx_data[DATA_W-1];
      end
      if (take_bit) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_q};
        cnt      <= cnt - CNT_ONE;
      end
      if (shift_out) begin
        tx_shift <= tx_shift << 1;
        miso     <= tx_shift[DATA_W-2];
      end
      if (present) miso <= tx_shift[DATA_W-1];
      if (commit)  rx_data <= rx_shift;
      if (state_nxt == IDLE) miso <= 1'b0;
    end
  end

  assign MISO = miso;
  assign busy = (state != IDLE);

endmodule
